// File: rtl/peripheral_bus_pkg.sv
// Shared types and helpers for the peripheral bus decoder.
// Holds the cycle-tracking FSM encoding and the channel index sizing.
package peripheral_bus_pkg;

    localparam int MAX_CHANNELS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } bus_state_t;

    // A single channel still needs a one-bit index register.
    function automatic int index_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/bus_window_match.sv
// One decode window: masked address compare qualified by enable and address space.
module bus_window_match #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] mask,
    input  logic                  enable,
    input  logic                  is_io,
    input  logic                  io_strobe,
    input  logic                  mem_strobe,
    output logic                  hit
);

    logic space_ok;

    assign space_ok = is_io ? io_strobe : mem_strobe;
    assign hit      = enable & space_ok & ((address & mask) == (base & mask));

endmodule

// File: rtl/peripheral_bus_decoder.sv
// Programmable N-window I/O and memory decoder with wait-state generation
// and a registered read-back multiplexer driving the CPU data bus.
module peripheral_bus_decoder
    import peripheral_bus_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_WIDTH = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic                             address_enable_n,
    input  logic                             io_read_n,
    input  logic                             io_write_n,
    input  logic                             memory_read_n,
    input  logic                             memory_write_n,
    input  logic                             interrupt_acknowledge_n,
    input  logic                             dma_ack,
    input  logic [CHANNELS-1:0]              window_enable,
    input  logic [CHANNELS-1:0]              window_is_io,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   window_base,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   window_mask,
    input  logic [CHANNELS*WAIT_WIDTH-1:0]   window_wait,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   channel_data_in,
    input  logic [DATA_WIDTH-1:0]            inta_data_in,
    input  logic [DATA_WIDTH-1:0]            dma_data_in,
    output logic [CHANNELS-1:0]              chip_select_n,
    output logic                             io_ready,
    output logic [DATA_WIDTH-1:0]            data_bus_out,
    output logic                             data_bus_out_from_chipset,
    output logic                             unclaimed_read
);

    localparam int IDX_W = index_width(CHANNELS);

    logic io_strobe, mem_strobe, strobe, read_cycle;

    assign io_strobe  = ~address_enable_n & (~io_read_n | ~io_write_n);
    assign mem_strobe = ~address_enable_n & (~memory_read_n | ~memory_write_n);
    assign strobe     = io_strobe | mem_strobe;
    // A read strobe wins over a simultaneous write strobe.
    assign read_cycle = ~io_read_n | ~memory_read_n;

    logic [CHANNELS-1:0] hit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_window
        bus_window_match #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_match (
            .address    (address),
            .base       (window_base[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .mask       (window_mask[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .enable     (window_enable[i]),
            .is_io      (window_is_io[i]),
            .io_strobe  (io_strobe),
            .mem_strobe (mem_strobe),
            .hit        (hit[i])
        );
    end

    // Isolating the lowest set bit gives the lowest-index winner directly.
    assign chip_select_n = ~(hit & (~hit + CHANNELS'(1)));

    logic [IDX_W-1:0]      winner_idx;
    logic [WAIT_WIDTH-1:0] winner_wait;
    logic                  any_hit;

    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        winner_idx  = '0;
        winner_wait = '0;
        any_hit     = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner_idx  = IDX_W'(i);
                winner_wait = window_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
                any_hit     = 1'b1;
            end
        end
    end

    bus_state_t            state_q, state_d;
    logic [WAIT_WIDTH-1:0] count_q, count_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic                  hit_q, hit_d;
    logic                  read_q, read_d;
    logic                  unclaimed_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sel_d       = sel_q;
        hit_d       = hit_q;
        read_d      = read_q;
        unclaimed_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    sel_d       = winner_idx;
                    hit_d       = any_hit;
                    read_d      = read_cycle;
                    count_d     = any_hit ? winner_wait : '0;
                    state_d     = (any_hit && winner_wait != '0) ? WAIT : ACTIVE;
                    unclaimed_d = ~any_hit & read_cycle;
                end
            end
            WAIT: begin
                if (!strobe) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q <= WAIT_WIDTH'(1)) begin
                    state_d = ACTIVE;
                    count_d = '0;
                end else begin
                    count_d = count_q - WAIT_WIDTH'(1);
                end
            end
            ACTIVE: begin
                if (!strobe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    logic [DATA_WIDTH-1:0] channel_word;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  enable_d;
    logic                  load_channel;

    // The _d selection equals the latched one outside IDLE, so the first
    // ACTIVE cycle already loads the winning channel.
    assign load_channel = (state_d == ACTIVE) & hit_d & read_d;

    always_comb begin
        channel_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_d == IDX_W'(i)) begin
                channel_word = channel_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        data_d   = '0;
        enable_d = 1'b0;
        if (!interrupt_acknowledge_n) begin
            data_d   = inta_data_in;
            enable_d = 1'b1;
        end else if (dma_ack && !io_read_n) begin
            data_d   = dma_data_in;
            enable_d = 1'b1;
        end else if (load_channel) begin
            data_d   = channel_word;
            enable_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q                   <= IDLE;
            count_q                   <= '0;
            sel_q                     <= '0;
            hit_q                     <= 1'b0;
            read_q                    <= 1'b0;
            data_bus_out              <= '0;
            data_bus_out_from_chipset <= 1'b0;
            unclaimed_read            <= 1'b0;
        end else begin
            state_q                   <= state_d;
            count_q                   <= count_d;
            sel_q                     <= sel_d;
            hit_q                     <= hit_d;
            read_q                    <= read_d;
            data_bus_out              <= data_d;
            data_bus_out_from_chipset <= enable_d;
            unclaimed_read            <= unclaimed_d;
        end
    end

    assign io_ready = (state_q != WAIT);

endmodule

// File: tb/tb_peripheral_bus_decoder.sv
// Directed bench for peripheral_bus_decoder with hand-computed expectations.
module tb_peripheral_bus_decoder;

    localparam int CHANNELS   = 8;
    localparam int ADDR_WIDTH = 20;
    localparam int DATA_WIDTH = 8;
    localparam int WAIT_WIDTH = 4;

    logic                           clock;
    logic                           reset_n;
    logic [ADDR_WIDTH-1:0]          address;
    logic                           address_enable_n;
    logic                           io_read_n;
    logic                           io_write_n;
    logic                           memory_read_n;
    logic                           memory_write_n;
    logic                           interrupt_acknowledge_n;
    logic                           dma_ack;
    logic [CHANNELS-1:0]            window_enable;
    logic [CHANNELS-1:0]            window_is_io;
    logic [CHANNELS*ADDR_WIDTH-1:0] window_base;
    logic [CHANNELS*ADDR_WIDTH-1:0] window_mask;
    logic [CHANNELS*WAIT_WIDTH-1:0] window_wait;
    logic [CHANNELS*DATA_WIDTH-1:0] channel_data_in;
    logic [DATA_WIDTH-1:0]          inta_data_in;
    logic [DATA_WIDTH-1:0]          dma_data_in;
    logic [CHANNELS-1:0]            chip_select_n;
    logic                           io_ready;
    logic [DATA_WIDTH-1:0]          data_bus_out;
    logic                           data_bus_out_from_chipset;
    logic                           unclaimed_read;

    int checks = 0;
    int errors = 0;

    peripheral_bus_decoder #(
        .CHANNELS   (CHANNELS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WAIT_WIDTH (WAIT_WIDTH)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .address                   (address),
        .address_enable_n          (address_enable_n),
        .io_read_n                 (io_read_n),
        .io_write_n                (io_write_n),
        .memory_read_n             (memory_read_n),
        .memory_write_n            (memory_write_n),
        .interrupt_acknowledge_n   (interrupt_acknowledge_n),
        .dma_ack                   (dma_ack),
        .window_enable             (window_enable),
        .window_is_io              (window_is_io),
        .window_base               (window_base),
        .window_mask               (window_mask),
        .window_wait               (window_wait),
        .channel_data_in           (channel_data_in),
        .inta_data_in              (inta_data_in),
        .dma_data_in               (dma_data_in),
        .chip_select_n             (chip_select_n),
        .io_ready                  (io_ready),
        .data_bus_out              (data_bus_out),
        .data_bus_out_from_chipset (data_bus_out_from_chipset),
        .unclaimed_read            (unclaimed_read)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_window(input int idx, input logic en, input logic io,
                              input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH-1:0] mask,
                              input logic [WAIT_WIDTH-1:0] ws, input logic [DATA_WIDTH-1:0] data);
        window_enable[idx]                          = en;
        window_is_io[idx]                           = io;
        window_base[idx*ADDR_WIDTH +: ADDR_WIDTH]   = base;
        window_mask[idx*ADDR_WIDTH +: ADDR_WIDTH]   = mask;
        window_wait[idx*WAIT_WIDTH +: WAIT_WIDTH]   = ws;
        channel_data_in[idx*DATA_WIDTH +: DATA_WIDTH] = data;
    endtask

    task automatic release_strobes();
        io_read_n      = 1'b1;
        io_write_n     = 1'b1;
        memory_read_n  = 1'b1;
        memory_write_n = 1'b1;
    endtask

    initial begin
        reset_n                 = 1'b0;
        address                 = '0;
        address_enable_n        = 1'b0;
        interrupt_acknowledge_n = 1'b1;
        dma_ack                 = 1'b0;
        inta_data_in            = '0;
        dma_data_in             = '0;
        window_enable           = '0;
        window_is_io            = '0;
        window_base             = '0;
        window_mask             = '0;
        window_wait             = '0;
        channel_data_in         = '0;
        release_strobes();

        set_window(0, 1'b1, 1'b1, 20'h00020, 20'h003FE, 4'd0, 8'h11);
        set_window(1, 1'b1, 1'b1, 20'h00040, 20'h003E0, 4'd0, 8'hA5);
        set_window(2, 1'b1, 1'b1, 20'h00060, 20'h003F0, 4'd0, 8'h22);
        set_window(3, 1'b1, 1'b1, 20'h003F0, 20'h003F8, 4'd5, 8'h33);
        set_window(4, 1'b0, 1'b1, 20'h00000, 20'h00000, 4'd0, 8'h44);
        set_window(5, 1'b1, 1'b0, 20'hB8000, 20'hF8000, 4'd3, 8'h55);
        set_window(6, 1'b1, 1'b1, 20'h00060, 20'h003F8, 4'd2, 8'h66);
        set_window(7, 1'b0, 1'b0, 20'hF0000, 20'hF0000, 4'd1, 8'h77);

        #12;
        check("reset io_ready", 32'(io_ready), 32'd1);
        check("reset data", 32'(data_bus_out), 32'h00);
        check("reset enable", 32'(data_bus_out_from_chipset), 32'd0);
        check("reset unclaimed", 32'(unclaimed_read), 32'd0);
        check("reset cs", 32'(chip_select_n), 32'hFF);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // IN 0x0041, window 1, no wait
        address = 20'h00041; io_read_n = 1'b0; #1;
        check("in41 cs", 32'(chip_select_n), 32'hFD);
        tick();
        check("in41 data", 32'(data_bus_out), 32'hA5);
        check("in41 enable", 32'(data_bus_out_from_chipset), 32'd1);
        check("in41 ready", 32'(io_ready), 32'd1);
        release_strobes();
        tick();
        check("in41 release enable", 32'(data_bus_out_from_chipset), 32'd0);
        check("in41 release data", 32'(data_bus_out), 32'h00);

        // MEMR 0xB8010, window 5, three wait states
        address = 20'hB8010; memory_read_n = 1'b0; #1;
        check("memr cs", 32'(chip_select_n), 32'hDF);
        check("memr ready before", 32'(io_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("memr wait ready", 32'(io_ready), 32'd0);
            check("memr wait enable", 32'(data_bus_out_from_chipset), 32'd0);
        end
        tick();
        check("memr ready back", 32'(io_ready), 32'd1);
        check("memr data", 32'(data_bus_out), 32'h55);
        check("memr enable", 32'(data_bus_out_from_chipset), 32'd1);
        release_strobes();
        tick();

        // Overlapping windows 2 and 6 at 0x0060; address moves after latch
        address = 20'h00060; io_read_n = 1'b0; #1;
        check("overlap cs", 32'(chip_select_n), 32'hFB);
        tick();
        check("overlap data", 32'(data_bus_out), 32'h22);
        check("overlap ready", 32'(io_ready), 32'd1);
        address = 20'h00041; #1;
        check("moved cs", 32'(chip_select_n), 32'hFD);
        tick();
        check("moved data stays", 32'(data_bus_out), 32'h22);
        release_strobes();
        tick();

        // IN 0x03FF, no window
        address = 20'h003FF; io_read_n = 1'b0; #1;
        check("unclaimed cs", 32'(chip_select_n), 32'hFF);
        tick();
        check("unclaimed pulse", 32'(unclaimed_read), 32'd1);
        check("unclaimed enable", 32'(data_bus_out_from_chipset), 32'd0);
        check("unclaimed ready", 32'(io_ready), 32'd1);
        tick();
        check("unclaimed pulse end", 32'(unclaimed_read), 32'd0);
        release_strobes();
        tick();

        // Abort during a five-cycle wait
        address = 20'h003F0; io_read_n = 1'b0; #1;
        check("abort cs", 32'(chip_select_n), 32'hF7);
        tick();
        check("abort wait1", 32'(io_ready), 32'd0);
        tick();
        check("abort wait2", 32'(io_ready), 32'd0);
        release_strobes();
        tick();
        check("abort ready", 32'(io_ready), 32'd1);
        check("abort enable", 32'(data_bus_out_from_chipset), 32'd0);
        tick();
        check("abort idle ready", 32'(io_ready), 32'd1);

        // Asynchronous reset while ACTIVE
        address = 20'h00041; io_read_n = 1'b0;
        tick();
        check("pre-reset data", 32'(data_bus_out), 32'hA5);
        #2 reset_n = 1'b0;
        #1;
        check("async reset data", 32'(data_bus_out), 32'h00);
        check("async reset enable", 32'(data_bus_out_from_chipset), 32'd0);
        check("async reset ready", 32'(io_ready), 32'd1);
        release_strobes();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post-reset ready", 32'(io_ready), 32'd1);
        check("post-reset enable", 32'(data_bus_out_from_chipset), 32'd0);

        // INTA and DMA override an active channel 0 read
        address = 20'h00020; io_read_n = 1'b0; #1;
        check("ch0 cs", 32'(chip_select_n), 32'hFE);
        tick();
        check("ch0 data", 32'(data_bus_out), 32'h11);
        interrupt_acknowledge_n = 1'b0; inta_data_in = 8'h08;
        tick();
        check("inta data", 32'(data_bus_out), 32'h08);
        check("inta enable", 32'(data_bus_out_from_chipset), 32'd1);
        interrupt_acknowledge_n = 1'b1;
        tick();
        check("ch0 data again", 32'(data_bus_out), 32'h11);
        dma_ack = 1'b1; dma_data_in = 8'h3C;
        tick();
        check("dma data", 32'(data_bus_out), 32'h3C);
        dma_ack = 1'b0;
        release_strobes();
        tick();
        check("dma release enable", 32'(data_bus_out_from_chipset), 32'd0);

        // Write cycle never drives the bus
        address = 20'h00041; io_write_n = 1'b0; #1;
        check("iow cs", 32'(chip_select_n), 32'hFD);
        tick();
        check("iow enable", 32'(data_bus_out_from_chipset), 32'd0);
        check("iow data", 32'(data_bus_out), 32'h00);
        release_strobes();
        tick();

        // Simultaneous read and write is a read
        io_read_n = 1'b0; io_write_n = 1'b0;
        tick();
        check("rw data", 32'(data_bus_out), 32'hA5);
        check("rw enable", 32'(data_bus_out_from_chipset), 32'd1);
        release_strobes();
        tick();

        // Unclaimed write gives no pulse
        address = 20'h003FF; io_write_n = 1'b0;
        tick();
        check("unclaimed write pulse", 32'(unclaimed_read), 32'd0);
        release_strobes();
        tick();

        // address_enable_n high blocks decode
        address = 20'h00041; address_enable_n = 1'b1; io_read_n = 1'b0; #1;
        check("aen cs", 32'(chip_select_n), 32'hFF);
        tick();
        check("aen enable", 32'(data_bus_out_from_chipset), 32'd0);
        check("aen unclaimed", 32'(unclaimed_read), 32'd0);
        release_strobes();
        address_enable_n = 1'b0;
        tick();

        // Memory read of an I/O-only address is unclaimed
        address = 20'h00041; memory_read_n = 1'b0; #1;
        check("mem space cs", 32'(chip_select_n), 32'hFF);
        tick();
        check("mem space unclaimed", 32'(unclaimed_read), 32'd1);
        release_strobes();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
